// File: rtl/serial_mag_comp_pkg.sv
// Shared definitions for the serial magnitude comparator: state encoding and
// width-derived sizing helpers.
package serial_mag_comp_pkg;

    // FSM state encoding
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_COMPARE = 2'd1;
    localparam state_t ST_DONE    = 2'd2;

    localparam int unsigned DEFAULT_WIDTH = 8;

    // Number of 2-bit slices in a WIDTH-bit operand
    function automatic int unsigned calc_nslice(input int unsigned width);
        return width / 2;
    endfunction

    // Slice index width; a single-slice operand still gets a 1-bit index
    function automatic int unsigned calc_idx_w(input int unsigned width);
        int unsigned ns;
        ns = width / 2;
        return (ns > 1) ? $clog2(ns) : 1;
    endfunction

    localparam int unsigned NSLICE = calc_nslice(DEFAULT_WIDTH);
    localparam int unsigned IDX_W  = calc_idx_w(DEFAULT_WIDTH);

endpackage

// File: rtl/serial_mag_comp_comp_2bit.sv
// 2-bit unsigned slice comparator cell: exactly one of eq/gt/lt is high.
module serial_mag_comp_comp_2bit (
    input  logic [1:0] i_a,
    input  logic [1:0] i_b,
    output logic       o_eq,
    output logic       o_gt,
    output logic       o_lt
);

    // Pure combinational compare of one slice pair
    always_comb begin
        o_eq = (i_a == i_b);
        o_gt = (i_a > i_b);
        o_lt = (i_a < i_b);
    end

endmodule

// File: rtl/serial_mag_comp.sv
// Multi-cycle unsigned magnitude comparator. Resolves two bits per clock,
// MSB slice first, and stops at the first unequal slice.
module serial_mag_comp
    import serial_mag_comp_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam int unsigned NSL  = calc_nslice(WIDTH);
    localparam int unsigned IDXW = calc_idx_w(WIDTH);

    state_t            r_state;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [IDXW-1:0]   r_idx;
    logic              r_eq;
    logic              r_gt;
    logic              r_lt;

    logic [1:0]        w_a_sl;
    logic [1:0]        w_b_sl;
    logic              w_sl_eq;
    logic              w_sl_gt;
    logic              w_sl_lt;

    // Select the operand slice pair addressed by the current index
    always_comb begin
        w_a_sl = '0;
        w_b_sl = '0;
        for (int i = 0; i < NSL; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_a_sl = r_a[2*i +: 2];
                w_b_sl = r_b[2*i +: 2];
            end
        end
    end

    serial_mag_comp_comp_2bit u_comp_2bit (
        .i_a  (w_a_sl),
        .i_b  (w_b_sl),
        .o_eq (w_sl_eq),
        .o_gt (w_sl_gt),
        .o_lt (w_sl_lt)
    );

    // FSM, slice index, operand capture and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_idx   <= '0;
            r_eq    <= 1'b0;
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_idx   <= IDXW'(NSL - 1);
                        r_eq    <= 1'b0;
                        r_gt    <= 1'b0;
                        r_lt    <= 1'b0;
                        r_state <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    if (w_sl_gt) begin
                        r_gt    <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (w_sl_lt) begin
                        r_lt    <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (r_idx == '0) begin
                        // Last slice and every slice matched
                        r_eq    <= w_sl_eq;
                        r_state <= ST_DONE;
                    end else begin
                        r_idx <= r_idx - IDXW'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state == ST_COMPARE) || (r_state == ST_DONE);
    assign done = (r_state == ST_DONE);
    assign eq   = r_eq;
    assign gt   = r_gt;
    assign lt   = r_lt;

endmodule

// File: tb/tb_serial_mag_comp.sv
// Randomized self-checking bench for serial_mag_comp, WIDTH=8 and WIDTH=2.
module tb_serial_mag_comp;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8, start2;
    logic [7:0] a8, b8;
    logic [1:0] a2, b2;
    logic       busy8, done8, eq8, gt8, lt8;
    logic       busy2, done2, eq2, gt2, lt2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_mag_comp #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .busy  (busy8),
        .done  (done8),
        .eq    (eq8),
        .gt    (gt8),
        .lt    (lt8)
    );

    serial_mag_comp #(.WIDTH(2)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start2),
        .a     (a2),
        .b     (b2),
        .busy  (busy2),
        .done  (done2),
        .eq    (eq2),
        .gt    (gt2),
        .lt    (lt2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int w, input logic s, input logic [7:0] x, input logic [7:0] y);
        if (w == 8) begin
            start8 = s;
            a8     = x;
            b8     = y;
        end else begin
            start2 = s;
            a2     = x[1:0];
            b2     = y[1:0];
        end
    endtask

    // 1-based position (from the MSB slice) of the first unequal slice, or ns if equal
    function automatic int first_diff(input logic [7:0] x, input logic [7:0] y, input int ns);
        for (int s = ns - 1; s >= 0; s--) begin
            if (((x >> (2 * s)) & 8'd3) != ((y >> (2 * s)) & 8'd3)) return ns - s;
        end
        return ns;
    endfunction

    // One full compare; result and per-cycle busy/done checked against the model
    task automatic run(input int w, input logic [7:0] ta_in, input logic [7:0] tb_in,
                       input bit poke);
        logic [7:0] ta, tb;
        logic [2:0] res, obs_r;
        logic       ob, od;
        int         ns, k;
        ta  = (w == 8) ? ta_in : {6'd0, ta_in[1:0]};
        tb  = (w == 8) ? tb_in : {6'd0, tb_in[1:0]};
        ns  = w / 2;
        k   = first_diff(ta, tb, ns);
        res = (ta == tb) ? 3'b100 : (ta > tb) ? 3'b010 : 3'b001;
        @(negedge clk);
        drive(w, 1'b1, ta, tb);
        for (int n = 1; n <= ns + 2; n++) begin
            @(negedge clk);
            ob    = (w == 8) ? busy8 : busy2;
            od    = (w == 8) ? done8 : done2;
            obs_r = (w == 8) ? {eq8, gt8, lt8} : {eq2, gt2, lt2};
            check($sformatf("busy w%0d a=%0h b=%0h c%0d", w, ta, tb, n), 32'(ob),
                  32'(n <= k + 1));
            check($sformatf("done w%0d a=%0h b=%0h c%0d", w, ta, tb, n), 32'(od),
                  32'(n == k + 1));
            check($sformatf("eqgtlt w%0d a=%0h b=%0h c%0d", w, ta, tb, n), 32'(obs_r),
                  (n >= k + 1) ? 32'(res) : 32'd0);
            // Operand changes while busy must not matter; extra starts must be ignored
            if (n <= k + 1)
                drive(w, poke && (n <= 3), 8'($urandom), 8'($urandom));
            else
                drive(w, 1'b0, ta, tb);
        end
    endtask

    initial begin
        logic [7:0] ra, rb;
        rst_n = 1'b0;
        drive(8, 1'b0, 8'h00, 8'h00);
        drive(2, 1'b0, 8'h00, 8'h00);
        repeat (3) @(negedge clk);
        check("reset busy8", 32'(busy8), 32'd0);
        check("reset done8", 32'(done8), 32'd0);
        check("reset res8", 32'({eq8, gt8, lt8}), 32'd0);
        check("reset busy2", 32'(busy2), 32'd0);
        check("reset res2", 32'({eq2, gt2, lt2}), 32'd0);
        rst_n = 1'b1;

        // Directed cases
        run(8, 8'hA5, 8'hA5, 1'b0);
        run(8, 8'h80, 8'h7F, 1'b0);
        run(8, 8'h12, 8'h13, 1'b0);
        run(8, 8'h00, 8'hFF, 1'b1);

        // Reset during COMPARE aborts without a done pulse
        @(negedge clk);
        drive(8, 1'b1, 8'h33, 8'h33);
        @(negedge clk);
        drive(8, 1'b0, 8'h33, 8'h33);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset busy", 32'(busy8), 32'd0);
        check("midreset done", 32'(done8), 32'd0);
        check("midreset res", 32'({eq8, gt8, lt8}), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("postreset done c%0d", i), 32'(done8), 32'd0);
            check($sformatf("postreset busy c%0d", i), 32'(busy8), 32'd0);
        end

        // Random compares with a spread of first-difference positions
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = ra ^ (8'($urandom_range(0, 3)) << (2 * $urandom_range(0, 3)));
            if (i % 4 == 0) rb = 8'($urandom);
            run(8, ra, rb, 1'($urandom));
        end

        // WIDTH=2: equal compare, then a start in the first IDLE cycle after DONE
        @(negedge clk);
        drive(2, 1'b1, 8'd2, 8'd2);
        @(negedge clk);
        drive(2, 1'b0, 8'd0, 8'd0);
        check("w2 b2b c1 busy", 32'(busy2), 32'd1);
        check("w2 b2b c1 res", 32'({eq2, gt2, lt2}), 32'd0);
        @(negedge clk);
        check("w2 b2b c2 done", 32'(done2), 32'd1);
        check("w2 b2b c2 res", 32'({eq2, gt2, lt2}), 32'b100);
        @(negedge clk);
        check("w2 b2b c3 busy", 32'(busy2), 32'd0);
        check("w2 b2b c3 res", 32'({eq2, gt2, lt2}), 32'b100);
        drive(2, 1'b1, 8'd1, 8'd3);
        @(negedge clk);
        drive(2, 1'b0, 8'd0, 8'd0);
        check("w2 b2b 2nd c1 busy", 32'(busy2), 32'd1);
        check("w2 b2b 2nd c1 done", 32'(done2), 32'd0);
        check("w2 b2b 2nd c1 res", 32'({eq2, gt2, lt2}), 32'd0);
        @(negedge clk);
        check("w2 b2b 2nd c2 done", 32'(done2), 32'd1);
        check("w2 b2b 2nd c2 res", 32'({eq2, gt2, lt2}), 32'b001);
        @(negedge clk);
        check("w2 b2b 2nd c3 busy", 32'(busy2), 32'd0);
        check("w2 b2b 2nd c3 res", 32'({eq2, gt2, lt2}), 32'b001);

        for (int i = 0; i < 8; i++) begin
            run(2, 8'($urandom), 8'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
